// File: rtl/cory_s2tap_pkg.sv
// Shared definitions for the two-requester tap-engine scheduler.
package cory_s2tap_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/cory_rr_arb2.sv
// Two-way round-robin arbiter; the pointer holds which requester wins a tie.
module cory_rr_arb2
    import cory_s2tap_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic               winner,
    output logic               any
);

    logic prio;

    always_comb begin
        any    = |req;
        winner = (req[0] && req[1]) ? prio : req[1];
    end

    // The loser of this decision gets priority next time.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            prio <= 1'b0;
        end else if (advance && any) begin
            prio <= ~winner;
        end
    end

endmodule

// File: rtl/cory_s2tap_sched.sv
// Shares one tap engine between two requesters, one line at a time.
module cory_s2tap_sched
    import cory_s2tap_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned T = 12,
    parameter int unsigned W = N * T,
    parameter int unsigned R = 11
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_c0_cmd_v,
    input  logic [R-1:0] i_c0_cmd_cnt,
    output logic         o_c0_cmd_r,
    input  logic         i_c1_cmd_v,
    input  logic [R-1:0] i_c1_cmd_cnt,
    output logic         o_c1_cmd_r,
    input  logic         i_a0_v,
    input  logic [N-1:0] i_a0_d,
    output logic         o_a0_r,
    input  logic         i_a1_v,
    input  logic [N-1:0] i_a1_d,
    output logic         o_a1_r,
    output logic         o_z0_v,
    output logic [W-1:0] o_z0_d,
    output logic [R-1:0] o_z0_cnt,
    output logic         o_z0_last,
    input  logic         i_z0_r,
    output logic         o_z1_v,
    output logic [W-1:0] o_z1_d,
    output logic [R-1:0] o_z1_cnt,
    output logic         o_z1_last,
    input  logic         i_z1_r,
    output logic         o_e_cmd_v,
    output logic [R-1:0] o_e_cmd_cnt,
    input  logic         i_e_cmd_r,
    output logic         o_e_a_v,
    output logic [N-1:0] o_e_a_d,
    input  logic         i_e_a_r,
    input  logic         i_e_z_v,
    input  logic [W-1:0] i_e_z_d,
    input  logic [R-1:0] i_e_z_cnt,
    input  logic         i_e_z_last,
    output logic         o_e_z_r,
    output logic         o_busy,
    output logic         o_err
);

    state_t       state, state_nxt;
    logic         grant;
    logic [R-1:0] cnt_q;
    logic [R-1:0] in_cnt;
    logic         winner, any;
    logic [R-1:0] win_cnt;
    logic         a_v_g, z_r_g, a_open;
    logic [N-1:0] a_d_g;
    logic [NUM_REQ-1:0] cmd_r, a_r, z_v;

    cory_rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({i_c1_cmd_v, i_c0_cmd_v}),
        .advance (state == IDLE),
        .winner  (winner),
        .any     (any)
    );

    assign win_cnt = winner ? i_c1_cmd_cnt : i_c0_cmd_cnt;
    assign a_v_g   = grant ? i_a1_v : i_a0_v;
    assign a_d_g   = grant ? i_a1_d : i_a0_d;
    assign z_r_g   = grant ? i_z1_r : i_z0_r;
    assign a_open  = (in_cnt < cnt_q);

    always_comb begin
        state_nxt   = state;
        cmd_r       = '0;
        a_r         = '0;
        z_v         = '0;
        o_e_cmd_v   = 1'b0;
        o_e_cmd_cnt = '0;
        o_e_a_v     = 1'b0;
        o_e_a_d     = '0;
        o_e_z_r     = 1'b0;
        o_err       = 1'b0;
        case (state)
            IDLE: begin
                // Zero-count drop acks from IDLE; gated so nothing leaks while reset is held.
                if (any && !reset_n) begin
                    if (win_cnt == '0) begin
                        o_err         = 1'b1;
                        cmd_r[winner] = 1'b1;
                    end else begin
                        state_nxt = CMD;
                    end
                end
            end
            CMD: begin
                o_e_cmd_v    = 1'b1;
                o_e_cmd_cnt  = cnt_q;
                cmd_r[grant] = i_e_cmd_r;
                if (i_e_cmd_r) state_nxt = RUN;
            end
            RUN: begin
                o_e_a_v    = a_open && a_v_g;
                o_e_a_d    = a_d_g;
                a_r[grant] = a_open && i_e_a_r;
                z_v[grant] = i_e_z_v;
                o_e_z_r    = z_r_g;
                if (i_e_z_v && z_r_g && i_e_z_last && (in_cnt == cnt_q)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state  <= IDLE;
            grant  <= 1'b0;
            cnt_q  <= '0;
            in_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any && win_cnt != '0) begin
                grant <= winner;
                cnt_q <= win_cnt;
            end
            if (state == CMD && i_e_cmd_r) begin
                in_cnt <= '0;
            end else if (o_e_a_v && i_e_a_r) begin
                in_cnt <= in_cnt + 1'b1;
            end
        end
    end

    assign o_c0_cmd_r = cmd_r[0];
    assign o_c1_cmd_r = cmd_r[1];
    assign o_a0_r     = a_r[0];
    assign o_a1_r     = a_r[1];
    assign o_z0_v     = z_v[0];
    assign o_z1_v     = z_v[1];
    assign o_z0_d     = i_e_z_d;
    assign o_z1_d     = i_e_z_d;
    assign o_z0_cnt   = i_e_z_cnt;
    assign o_z1_cnt   = i_e_z_cnt;
    assign o_z0_last  = i_e_z_last;
    assign o_z1_last  = i_e_z_last;
    assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_cory_s2tap_sched.sv
// Directed bench: requesters, tap engine and scoreboard are modelled here.
module tb_cory_s2tap_sched;

    localparam int N = 8;
    localparam int T = 12;
    localparam int W = N * T;
    localparam int R = 11;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic         i_c0_cmd_v, o_c0_cmd_r, i_c1_cmd_v, o_c1_cmd_r;
    logic [R-1:0] i_c0_cmd_cnt, i_c1_cmd_cnt;
    logic         i_a0_v, o_a0_r, i_a1_v, o_a1_r;
    logic [N-1:0] i_a0_d, i_a1_d;
    logic         o_z0_v, o_z0_last, i_z0_r, o_z1_v, o_z1_last, i_z1_r;
    logic [W-1:0] o_z0_d, o_z1_d;
    logic [R-1:0] o_z0_cnt, o_z1_cnt;
    logic         o_e_cmd_v, i_e_cmd_r, o_e_a_v, i_e_a_r;
    logic [R-1:0] o_e_cmd_cnt, i_e_z_cnt;
    logic [N-1:0] o_e_a_d;
    logic         i_e_z_v, i_e_z_last, o_e_z_r, o_busy, o_err;
    logic [W-1:0] i_e_z_d;

    cory_s2tap_sched #(.N(N), .T(T), .W(W), .R(R)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_c0_cmd_v(i_c0_cmd_v), .i_c0_cmd_cnt(i_c0_cmd_cnt), .o_c0_cmd_r(o_c0_cmd_r),
        .i_c1_cmd_v(i_c1_cmd_v), .i_c1_cmd_cnt(i_c1_cmd_cnt), .o_c1_cmd_r(o_c1_cmd_r),
        .i_a0_v(i_a0_v), .i_a0_d(i_a0_d), .o_a0_r(o_a0_r),
        .i_a1_v(i_a1_v), .i_a1_d(i_a1_d), .o_a1_r(o_a1_r),
        .o_z0_v(o_z0_v), .o_z0_d(o_z0_d), .o_z0_cnt(o_z0_cnt), .o_z0_last(o_z0_last), .i_z0_r(i_z0_r),
        .o_z1_v(o_z1_v), .o_z1_d(o_z1_d), .o_z1_cnt(o_z1_cnt), .o_z1_last(o_z1_last), .i_z1_r(i_z1_r),
        .o_e_cmd_v(o_e_cmd_v), .o_e_cmd_cnt(o_e_cmd_cnt), .i_e_cmd_r(i_e_cmd_r),
        .o_e_a_v(o_e_a_v), .o_e_a_d(o_e_a_d), .i_e_a_r(i_e_a_r),
        .i_e_z_v(i_e_z_v), .i_e_z_d(i_e_z_d), .i_e_z_cnt(i_e_z_cnt), .i_e_z_last(i_e_z_last),
        .o_e_z_r(o_e_z_r), .o_busy(o_busy), .o_err(o_err)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting at %0t", nm, $time);
    endtask

    // Requester, engine and scoreboard state
    int           cmdq0[$], cmdq1[$];
    logic [N-1:0] sq0[$], sq1[$], expd0[$], expd1[$];
    int           lnq0[$], lnq1[$];
    int           bidx0, bidx1, sd0, sd1;
    bit           eng_busy;
    int           eng_cnt, eng_rx, eng_tx;
    logic [N-1:0] eq[$];
    bit           arand, zrand, prev_last;
    int           err_seen, cmd_seen, first_cmd_cnt, zbeats0, zbeats1;
    int           glog[$];

    task automatic clear_models();
        cmdq0.delete(); cmdq1.delete(); sq0.delete(); sq1.delete();
        expd0.delete(); expd1.delete(); lnq0.delete(); lnq1.delete(); eq.delete(); glog.delete();
        bidx0 = 0; bidx1 = 0; eng_busy = 0; eng_cnt = 0; eng_rx = 0; eng_tx = 0;
        prev_last = 0; err_seen = 0; cmd_seen = 0; first_cmd_cnt = -1; zbeats0 = 0; zbeats1 = 0;
    endtask

    task automatic push_line(input int k, input int c);
        logic [N-1:0] d;
        if (k == 0) cmdq0.push_back(c); else cmdq1.push_back(c);
        for (int i = 0; i < c; i++) begin
            if (k == 0) begin
                d = N'(sd0 % 128); sd0++;
                sq0.push_back(d); expd0.push_back(d);
            end else begin
                d = N'(8'h80 + (sd1 % 128)); sd1++;
                sq1.push_back(d); expd1.push_back(d);
            end
        end
        if (c > 0) begin
            if (k == 0) lnq0.push_back(c); else lnq1.push_back(c);
        end
    endtask

    task automatic drive();
        logic [W-1:0] zd;
        i_c0_cmd_v   = (cmdq0.size() != 0);
        i_c0_cmd_cnt = (cmdq0.size() != 0) ? R'(cmdq0[0]) : '0;
        i_c1_cmd_v   = (cmdq1.size() != 0);
        i_c1_cmd_cnt = (cmdq1.size() != 0) ? R'(cmdq1[0]) : '0;
        i_a0_v = (sq0.size() != 0);
        i_a0_d = (sq0.size() != 0) ? sq0[0] : '0;
        i_a1_v = (sq1.size() != 0);
        i_a1_d = (sq1.size() != 0) ? sq1[0] : '0;
        i_z0_r = zrand ? ($urandom_range(0, 1) == 1) : 1'b1;
        i_z1_r = zrand ? ($urandom_range(0, 1) == 1) : 1'b1;
        i_e_cmd_r = !eng_busy;
        i_e_a_r   = eng_busy && (eng_rx < eng_cnt) && (arand ? ($urandom_range(0, 1) == 1) : 1'b1);
        zd = '0;
        if (eq.size() != 0) begin
            zd[N-1:0] = eq[0];
            zd[15:8]  = 8'(eng_tx);
        end
        i_e_z_v    = (eq.size() != 0);
        i_e_z_d    = zd;
        i_e_z_cnt  = R'(eng_cnt);
        i_e_z_last = (eq.size() != 0) && (eng_tx == eng_cnt - 1);
    endtask

    task automatic observe();
        bit c0, c1, ec, ea, ez, a0, a1, z0, z1;
        bit exp_last;
        c0 = i_c0_cmd_v && o_c0_cmd_r;  c1 = i_c1_cmd_v && o_c1_cmd_r;
        ec = o_e_cmd_v && i_e_cmd_r;    ea = o_e_a_v && i_e_a_r;
        ez = i_e_z_v && o_e_z_r;
        a0 = i_a0_v && o_a0_r;          a1 = i_a1_v && o_a1_r;
        z0 = o_z0_v && i_z0_r;          z1 = o_z1_v && i_z1_r;
        if (prev_last) chk("busy_after_last", longint'(o_busy), 0);
        prev_last = ez && i_e_z_last;
        if (o_err) begin
            err_seen++;
            chk("err_ack", longint'(c0) + longint'(c1), 1);
        end
        if (ec) begin
            cmd_seen++;
            if (cmd_seen == 1) first_cmd_cnt = int'(o_e_cmd_cnt);
            glog.push_back(c1 ? 1 : 0);
            chk("cmd_ack", longint'(c0) + longint'(c1), 1);
            eng_busy = 1; eng_cnt = int'(o_e_cmd_cnt); eng_rx = 0; eng_tx = 0;
        end
        if (c0) void'(cmdq0.pop_front());
        if (c1) void'(cmdq1.pop_front());
        if (ea || a0 || a1) chk("a_hs", longint'(a0) + longint'(a1), longint'(ea));
        if (ea) begin
            eq.push_back(o_e_a_d);
            eng_rx++;
        end
        if (a0) void'(sq0.pop_front());
        if (a1) void'(sq1.pop_front());
        if (ez || z0 || z1) chk("z_hs", longint'(z0) + longint'(z1), longint'(ez));
        if (ez) begin
            if (eq.size() != 0) void'(eq.pop_front());
            if (eng_tx == eng_cnt - 1) eng_busy = 0;
            eng_tx++;
        end
        if (z0) begin
            zbeats0++;
            if (expd0.size() == 0 || lnq0.size() == 0) begin
                timeout("z0_extra_beat");
            end else begin
                exp_last = (bidx0 == lnq0[0] - 1);
                chk("z0_data", longint'(o_z0_d[N-1:0]), longint'(expd0[0]));
                chk("z0_cnt", longint'(o_z0_cnt), longint'(lnq0[0]));
                chk("z0_last", longint'(o_z0_last), longint'(exp_last));
                void'(expd0.pop_front());
                bidx0++;
                if (exp_last) begin void'(lnq0.pop_front()); bidx0 = 0; end
            end
        end
        if (z1) begin
            zbeats1++;
            if (expd1.size() == 0 || lnq1.size() == 0) begin
                timeout("z1_extra_beat");
            end else begin
                exp_last = (bidx1 == lnq1[0] - 1);
                chk("z1_data", longint'(o_z1_d[N-1:0]), longint'(expd1[0]));
                chk("z1_cnt", longint'(o_z1_cnt), longint'(lnq1[0]));
                chk("z1_last", longint'(o_z1_last), longint'(exp_last));
                void'(expd1.pop_front());
                bidx1++;
                if (exp_last) begin void'(lnq1.pop_front()); bidx1 = 0; end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        drive();
    endtask

    function automatic bit all_done();
        return cmdq0.size() == 0 && cmdq1.size() == 0 && sq0.size() == 0 && sq1.size() == 0
            && !eng_busy && eq.size() == 0 && o_busy == 1'b0;
    endfunction

    task automatic run_idle(input string nm);
        int n;
        n = 0;
        while (!all_done() && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) timeout(nm);
        repeat (3) tick();
    endtask

    task automatic check_quiet(input string nm);
        chk(nm, longint'({o_c0_cmd_r, o_c1_cmd_r, o_a0_r, o_a1_r, o_z0_v, o_z1_v,
                          o_e_cmd_v, o_e_a_v, o_e_z_r, o_busy, o_err}), 0);
        chk({nm, "_cmd_cnt"}, longint'(o_e_cmd_cnt), 0);
    endtask

    // Reset with busy-looking inputs so the gating is actually exercised.
    task automatic do_reset();
        reset_n = 1'b1;
        i_c0_cmd_v = 1'b1; i_c0_cmd_cnt = R'(3); i_c1_cmd_v = 1'b1; i_c1_cmd_cnt = '0;
        i_a0_v = 1'b1; i_a1_v = 1'b1; i_z0_r = 1'b1; i_z1_r = 1'b1;
        i_e_cmd_r = 1'b1; i_e_a_r = 1'b1; i_e_z_v = 1'b1; i_e_z_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset_state");
        clear_models();
        drive();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        drive();
    endtask

    typedef struct {
        bit v0; int c0; bit v1; int c1; bit bp;
        int exp_cmds; int exp_first_cnt; int exp_first_owner; int exp_err; int exp_z0; int exp_z1;
    } vec_t;

    vec_t vt[7];
    int   alt_exp[4];
    int   n;

    initial begin
        sd0 = 0; sd1 = 0; arand = 0; zrand = 0;
        clear_models();
        vt[0] = '{1, 5, 0, 0, 0, 1, 5, 0, 0, 5, 0};
        vt[1] = '{1, 3, 1, 4, 0, 2, 3, 0, 0, 3, 4};
        vt[2] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
        vt[3] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 0, 1};
        vt[4] = '{1, 2, 1, 0, 0, 1, 2, 0, 1, 2, 0};
        vt[5] = '{1, 7, 0, 0, 1, 1, 7, 0, 0, 7, 0};
        vt[6] = '{1, 7, 1, 7, 1, 2, 7, 0, 0, 7, 7};

        for (int i = 0; i < 7; i++) begin
            arand = vt[i].bp; zrand = vt[i].bp;
            do_reset();
            if (vt[i].v0) push_line(0, vt[i].c0);
            if (vt[i].v1) push_line(1, vt[i].c1);
            drive();
            run_idle("vec_done");
            chk("vec_cmds", cmd_seen, vt[i].exp_cmds);
            chk("vec_err", err_seen, vt[i].exp_err);
            chk("vec_z0_beats", zbeats0, vt[i].exp_z0);
            chk("vec_z1_beats", zbeats1, vt[i].exp_z1);
            chk("vec_z0_left", expd0.size(), 0);
            chk("vec_z1_left", expd1.size(), 0);
            if (vt[i].exp_cmds > 0) begin
                chk("vec_first_cnt", first_cmd_cnt, vt[i].exp_first_cnt);
                chk("vec_first_owner", (glog.size() != 0) ? glog[0] : -1, vt[i].exp_first_owner);
            end
        end

        // req0 holds its command line busy; req1 asks once after req0's first grant.
        arand = 0; zrand = 0;
        do_reset();
        push_line(0, 1); push_line(0, 1); push_line(0, 1);
        drive();
        n = 0;
        while (cmd_seen == 0 && n < 200) begin tick(); n++; end
        if (n >= 200) timeout("alt_first_grant");
        push_line(1, 1);
        drive();
        run_idle("alt_done");
        alt_exp[0] = 0; alt_exp[1] = 1; alt_exp[2] = 0; alt_exp[3] = 0;
        chk("alt_count", glog.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("alt_order", (i < glog.size()) ? glog[i] : -1, alt_exp[i]);

        // Reset lands mid-line after two samples have reached the engine.
        do_reset();
        push_line(0, 6);
        drive();
        n = 0;
        while (eng_rx < 2 && n < 200) begin tick(); n++; end
        if (n >= 200) timeout("mid_two_samples");
        chk("mid_busy_before", longint'(o_busy), 1);
        reset_n = 1'b1;
        #1;
        check_quiet("mid_reset");
        clear_models();
        drive();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        drive();
        push_line(0, 2);
        drive();
        run_idle("mid_recover");
        chk("mid_cmds", cmd_seen, 1);
        chk("mid_first_cnt", first_cmd_cnt, 2);
        chk("mid_z0_beats", zbeats0, 2);
        chk("mid_z0_left", expd0.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
